mmu_req_arbiter: RTL and testbench
==================================

# mmu_req_arbiter

Sequencer and arbiter in front of the MMU translation port and its CP0 TLB-maintenance port. It shares the single MMU between three requesters: instruction fetch (IF), data access (DM) and CP0 TLB instructions (TLBR/TLBP/TLBWI). It drives the MMU request strobes one transaction at a time and guarantees that processor translations and CP0 reads never overlap. It also returns registered translation results and a timeout-protected acknowledge to each requester.

## Interface
- TIMEOUT, 15: cycles to wait for an MMU acknowledge before forcing an error completion; range 2..255.
- clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- IF_Req  in  1  fetch translation request, level
- IF_VAddr  in  32  fetch virtual address, stable while IF_Req=1
- DM_Req  in  1  data translation request, level
- DM_VAddr  in  32  data virtual address
- DM_Wr  in  1  1 = store, 0 = load
- CP0_Req  in  1  TLB maintenance request, level
- CP0_Wr  in  1  1 = TLBWI, 0 = TLBR/TLBP
- CP0_Func  in  2  `MMU_TLBR or `MMU_TLBP, passed to MMU
- MMU_Pr_Ack, MMU_CP0_AckR, MMU_CP0_AckP  in  1 each  MMU completions
- MMU_Pr_RAddr  in  32; TLB_Fault  in  3; TLB_Error  in  1  MMU translation results
- Pr_Req  out  1; Pr_VAddr  out  32; RW_En  out  1  MMU processor port
- CP0_RdReq, CP0_WrReq  out  1 each; CP0_MMU_Func  out  2  MMU CP0 port
- IF_Ack, DM_Ack  out  1  one-cycle completion pulses
- Rsp_RAddr  out  32; Rsp_Fault  out  3; Rsp_Err  out  1; Rsp_Timeout  out  1  registered result, valid with IF_Ack/DM_Ack
- CP0_Ack  out  1  TLB op complete

## Operation
- States: IDLE, PR_ISSUE, PR_DONE, CP0_RD, CP0_WR.
- IDLE: priority is CP0_Req first, then the IF/DM pick. CP0_Req with CP0_Wr=1 goes to CP0_WR; with CP0_Wr=0 it goes to CP0_RD. Otherwise the IF/DM winner latches grant, VAddr and RW, then goes to PR_ISSUE. No request keeps the FSM in IDLE.
- PR_ISSUE: Pr_Req=1 with latched Pr_VAddr/RW_En (IF has RW_En=0). Watchdog counter counts from 0.
  - On MMU_Pr_Ack=1: capture MMU_Pr_RAddr, TLB_Fault and TLB_Error into Rsp_*, set Rsp_Timeout=0, go to PR_DONE.
  - If the counter reaches TIMEOUT-1 without an ack: Rsp_RAddr=0, Rsp_Fault=0, Rsp_Err=1, Rsp_Timeout=1, go to PR_DONE.
- PR_DONE: Pr_Req=0. The granted requester's Ack pulses for exactly this cycle. Next state is IDLE. This cycle also covers the MMU's one-cycle fault-sampling extension.
- CP0_RD: CP0_RdReq=1, CP0_MMU_Func=CP0_Func, Pr_Req=0.
  - CP0_Ack = MMU_CP0_AckR | MMU_CP0_AckP, combinational, so CP0 samples MMU_CP0_* in the same cycle. Go to IDLE on ack.
  - Timeout applies: CP0_Ack is forced high at TIMEOUT-1, then IDLE.
- CP0_WR: CP0_WrReq=1 for exactly one cycle, CP0_Ack=1 in the same cycle, then IDLE.
- Pr_Req and CP0_RdReq/CP0_WrReq are never high together.
- Rsp_* hold their value until the next processor completion.

## Timing
- Reset (Reset=0 at a rising edge) gives state IDLE. All outputs are 0: Pr_Req, Pr_VAddr, RW_En, CP0_RdReq, CP0_WrReq, CP0_MMU_Func, the Acks, Rsp_*. Watchdog=0. Round-robin pointer points to IF.
- Reset mid-transaction aborts it with no Ack. Requests still high are re-arbitrated from the first cycle after reset.
- Processor latency, with an MMU that acks one cycle after Pr_Req:
  - Request seen in IDLE at cycle 0.
  - Pr_Req high in cycle 1.
  - MMU_Pr_Ack in cycle 2.
  - IF_Ack/DM_Ack in cycle 3.
  - IDLE in cycle 4.
- Requesters must drop or replace Req in the cycle after Ack. Req is sampled only in IDLE, so a Req still high in cycle 4 starts a new transaction.
- A requester dropping Req before Ack is a protocol violation; the transaction still completes and Acks.
- CP0 read latency is 2 cycles, request to CP0_Ack with a 1-cycle MMU. TLBWI latency is 1 cycle.
- Watchdog is 8 bits and saturates; the timeout path completes after exactly TIMEOUT cycles in PR_ISSUE/CP0_RD.

## Configuration
- MMU_ARB_RR_EN defined: IF vs DM arbitration is round-robin. After a grant the pointer moves to the other requester, so simultaneous IF and DM alternate.
- Undefined: fixed priority with DM over IF. The pointer is removed and IF is served only when DM_Req=0.
- CP0 priority is highest in both builds.

## Test plan
- IF_Req, VAddr 0x0040_1234, MMU acks in cycle 2 with RAddr 0x0001_2234, Fault 0 -> Pr_Req high cycle 1 only through ack, IF_Ack cycle 3, Rsp_RAddr=0x0001_2234, Rsp_Err=0.
- IF_Req and DM_Req held together for 4 transactions -> RR build grants IF, DM, IF, DM; non-RR build grants DM four times.
- CP0_Req (TLBP) and DM_Req in the same cycle -> CP0_RdReq first, CP0_Ack with MMU_CP0_AckP; then the DM transaction. Pr_Req=0 throughout CP0_RD.
- DM store, MMU never acks, TIMEOUT=15 -> DM_Ack exactly 15 cycles after Pr_Req rises, Rsp_Err=1, Rsp_Timeout=1, Rsp_RAddr=0.
- CP0_Req with CP0_Wr=1 -> CP0_WrReq and CP0_Ack high for exactly one cycle, then IDLE.
- Reset=0 in PR_ISSUE, IF_Req kept high -> no IF_Ack, all outputs 0; Pr_Req rises again one cycle after reset release.

Source files
------------

// File: rtl/mmu_req_arbiter_if.sv
// mmu_req_arbiter_if
//   Bundles every signal between the MMU request arbiter, its three requesters
//   (instruction fetch, data access, CP0 TLB maintenance) and the shared MMU.
//
//   Handshake semantics: requests (IF_Req, DM_Req, CP0_Req) are levels that
//   stay high, with stable address and control, until the matching
//   acknowledge. IF_Ack and DM_Ack are one-cycle pulses; Rsp_* are valid in
//   that cycle. CP0_Ack is high in the cycle the TLB operation completes. On
//   the MMU side, Pr_Req and CP0_RdReq are levels held until an MMU
//   completion (or the watchdog). CP0_WrReq is a one-cycle strobe.
//
//   Modports:
//     slave  - arbiter view: requester and MMU inputs, MMU strobes and
//              requester responses as outputs.
//     master - environment view: the requesters and the MMU together.
interface mmu_req_arbiter_if;
    // Requesters
    logic        IF_Req;
    logic [31:0] IF_VAddr;
    logic        DM_Req;
    logic [31:0] DM_VAddr;
    logic        DM_Wr;
    logic        CP0_Req;
    logic        CP0_Wr;
    logic [1:0]  CP0_Func;
    // MMU completions and translation results
    logic        MMU_Pr_Ack;
    logic        MMU_CP0_AckR;
    logic        MMU_CP0_AckP;
    logic [31:0] MMU_Pr_RAddr;
    logic [2:0]  TLB_Fault;
    logic        TLB_Error;
    // MMU processor and CP0 ports
    logic        Pr_Req;
    logic [31:0] Pr_VAddr;
    logic        RW_En;
    logic        CP0_RdReq;
    logic        CP0_WrReq;
    logic [1:0]  CP0_MMU_Func;
    // Responses to requesters
    logic        IF_Ack;
    logic        DM_Ack;
    logic [31:0] Rsp_RAddr;
    logic [2:0]  Rsp_Fault;
    logic        Rsp_Err;
    logic        Rsp_Timeout;
    logic        CP0_Ack;

    modport slave (
        input  IF_Req, IF_VAddr, DM_Req, DM_VAddr, DM_Wr,
        input  CP0_Req, CP0_Wr, CP0_Func,
        input  MMU_Pr_Ack, MMU_CP0_AckR, MMU_CP0_AckP,
        input  MMU_Pr_RAddr, TLB_Fault, TLB_Error,
        output Pr_Req, Pr_VAddr, RW_En, CP0_RdReq, CP0_WrReq, CP0_MMU_Func,
        output IF_Ack, DM_Ack, Rsp_RAddr, Rsp_Fault, Rsp_Err, Rsp_Timeout,
        output CP0_Ack
    );

    modport master (
        output IF_Req, IF_VAddr, DM_Req, DM_VAddr, DM_Wr,
        output CP0_Req, CP0_Wr, CP0_Func,
        output MMU_Pr_Ack, MMU_CP0_AckR, MMU_CP0_AckP,
        output MMU_Pr_RAddr, TLB_Fault, TLB_Error,
        input  Pr_Req, Pr_VAddr, RW_En, CP0_RdReq, CP0_WrReq, CP0_MMU_Func,
        input  IF_Ack, DM_Ack, Rsp_RAddr, Rsp_Fault, Rsp_Err, Rsp_Timeout,
        input  CP0_Ack
    );
endinterface

// File: rtl/mmu_req_arbiter.sv
// mmu_req_arbiter
//   Shares one MMU between instruction fetch, data access and CP0 TLB
//   maintenance. Only one transaction is outstanding at a time, so processor
//   translations and CP0 TLB operations never overlap. Translation results
//   are registered and returned with a one-cycle IF_Ack/DM_Ack. An 8-bit
//   watchdog forces an error completion after TIMEOUT cycles without an MMU
//   acknowledge.
//
//   Parameters:
//     TIMEOUT (2..255) - cycles spent waiting in PR_ISSUE/CP0_RD before the
//                        forced completion.
//   Build option:
//     MMU_ARB_RR_EN    - defined: IF/DM round-robin.
//                        undefined: DM has fixed priority over IF.
//                        CP0 always has the highest priority.
//   Ports:
//     clk       - rising-edge clock
//     Reset     - synchronous, active-low reset
//     bus       - mmu_req_arbiter_if.slave (requesters + MMU)
//     fsm_state - current FSM state, for debug
module mmu_req_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             Reset,
    mmu_req_arbiter_if.slave bus,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PR_ISSUE = 3'd1,
        PR_DONE  = 3'd2,
        CP0_RD   = 3'd3,
        CP0_WR   = 3'd4
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  watchdog;
    logic        wd_expired;
    logic        start_pr;
    logic        pick_dm;
    logic        grant_dm;
    logic [31:0] vaddr_q;
    logic        rw_q;
    logic [31:0] rsp_raddr_q;
    logic [2:0]  rsp_fault_q;
    logic        rsp_err_q;
    logic        rsp_timeout_q;

    // The watchdog value of the last allowed waiting cycle.
    assign wd_expired = (watchdog == WD_LAST);

    // A processor transaction starts only when no CP0 request competes.
    assign start_pr = (state == IDLE) && !bus.CP0_Req && (bus.IF_Req || bus.DM_Req);

`ifdef MMU_ARB_RR_EN
    // rr_ptr = 0: IF wins a tie; 1: DM wins a tie.
    logic rr_ptr;

    assign pick_dm = bus.DM_Req && (!bus.IF_Req || rr_ptr);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            rr_ptr <= 1'b0;
        end else if (start_pr) begin
            // Hand the tie-break to whoever did not just win.
            rr_ptr <= !pick_dm;
        end
    end
`else
    assign pick_dm = bus.DM_Req;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.CP0_Req) begin
                    state_next = bus.CP0_Wr ? CP0_WR : CP0_RD;
                end else if (bus.IF_Req || bus.DM_Req) begin
                    state_next = PR_ISSUE;
                end
            end
            PR_ISSUE: begin
                if (bus.MMU_Pr_Ack || wd_expired) state_next = PR_DONE;
            end
            PR_DONE:  state_next = IDLE;
            CP0_RD: begin
                if (bus.MMU_CP0_AckR || bus.MMU_CP0_AckP || wd_expired) state_next = IDLE;
            end
            CP0_WR:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state         <= IDLE;
            watchdog      <= 8'd0;
            grant_dm      <= 1'b0;
            vaddr_q       <= 32'd0;
            rw_q          <= 1'b0;
            rsp_raddr_q   <= 32'd0;
            rsp_fault_q   <= 3'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state <= state_next;

            // Count only while staying in a waiting state; restart from 0
            // on every entry.
            if ((state == PR_ISSUE || state == CP0_RD) && state_next == state) begin
                if (watchdog != 8'hFF) watchdog <= watchdog + 8'd1;
            end else begin
                watchdog <= 8'd0;
            end

            if (start_pr) begin
                grant_dm <= pick_dm;
                vaddr_q  <= pick_dm ? bus.DM_VAddr : bus.IF_VAddr;
                rw_q     <= pick_dm && bus.DM_Wr;
            end

            // A real acknowledge wins over a watchdog expiry in the same cycle.
            if (state == PR_ISSUE) begin
                if (bus.MMU_Pr_Ack) begin
                    rsp_raddr_q   <= bus.MMU_Pr_RAddr;
                    rsp_fault_q   <= bus.TLB_Fault;
                    rsp_err_q     <= bus.TLB_Error;
                    rsp_timeout_q <= 1'b0;
                end else if (wd_expired) begin
                    rsp_raddr_q   <= 32'd0;
                    rsp_fault_q   <= 3'd0;
                    rsp_err_q     <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Pr_Req       = (state == PR_ISSUE);
    assign bus.Pr_VAddr     = vaddr_q;
    assign bus.RW_En        = rw_q;
    assign bus.CP0_RdReq    = (state == CP0_RD);
    assign bus.CP0_WrReq    = (state == CP0_WR);
    assign bus.CP0_MMU_Func = (state == CP0_RD) ? bus.CP0_Func : 2'b00;
    assign bus.IF_Ack       = (state == PR_DONE) && !grant_dm;
    assign bus.DM_Ack       = (state == PR_DONE) && grant_dm;
    assign bus.Rsp_RAddr    = rsp_raddr_q;
    assign bus.Rsp_Fault    = rsp_fault_q;
    assign bus.Rsp_Err      = rsp_err_q;
    assign bus.Rsp_Timeout  = rsp_timeout_q;
    // Combinational so CP0 samples the MMU CP0 results in the ack cycle.
    assign bus.CP0_Ack      = (state == CP0_WR) ||
                              ((state == CP0_RD) &&
                               (bus.MMU_CP0_AckR || bus.MMU_CP0_AckP || wd_expired));

    assign fsm_state = state;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// tb_mmu_req_arbiter
//   Directed testbench for mmu_req_arbiter (TIMEOUT = 15). Inputs change 2 time
//   units after a rising edge; outputs are sampled 1 unit after that. "cycle n"
//   in the comments counts rising edges from the request cycle (cycle 0).
//   Expected IF/DM grant order follows MMU_ARB_RR_EN.
module tb_mmu_req_arbiter;

    localparam logic [1:0] TLBR = 2'd0;
    localparam logic [1:0] TLBP = 2'd1;

    logic       clk;
    logic       Reset;
    logic [2:0] fsm_state;

    int n_checks;
    int n_fail;

    logic [0:0] exp_q[$];

    mmu_req_arbiter_if bus ();

    mmu_req_arbiter #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        bus.IF_Req       = 1'b0;
        bus.IF_VAddr     = 32'd0;
        bus.DM_Req       = 1'b0;
        bus.DM_VAddr     = 32'd0;
        bus.DM_Wr        = 1'b0;
        bus.CP0_Req      = 1'b0;
        bus.CP0_Wr       = 1'b0;
        bus.CP0_Func     = 2'd0;
        bus.MMU_Pr_Ack   = 1'b0;
        bus.MMU_CP0_AckR = 1'b0;
        bus.MMU_CP0_AckP = 1'b0;
        bus.MMU_Pr_RAddr = 32'd0;
        bus.TLB_Fault    = 3'd0;
        bus.TLB_Error    = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for Pr_Req, acks it in that cycle with the given result,
    // then returns the acks seen in the following cycle.
    task automatic pr_txn(input logic [31:0] raddr, input logic [2:0] fault, input logic err,
                          output int lat, output logic [31:0] vaddr, output logic rw,
                          output logic got_if, output logic got_dm);
        lat = 0;
        while (!bus.Pr_Req && lat < 20) begin
            tick();
            lat++;
        end
        vaddr = bus.Pr_VAddr;
        rw    = bus.RW_En;
        bus.MMU_Pr_Ack   = 1'b1;
        bus.MMU_Pr_RAddr = raddr;
        bus.TLB_Fault    = fault;
        bus.TLB_Error    = err;
        tick();
        bus.MMU_Pr_Ack = 1'b0;
        #1;
        got_if = bus.IF_Ack;
        got_dm = bus.DM_Ack;
    endtask

    initial begin
        int          lat;
        int          n;
        logic [31:0] va;
        logic        rw;
        logic        gi;
        logic        gd;
        logic        exp_dm;
        logic        pr_dropped;

        n_checks = 0;
        n_fail   = 0;
        drive_idle();
        Reset = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_state", fsm_state, 0);
        check("rst_pr_req", bus.Pr_Req, 0);
        check("rst_pr_vaddr", bus.Pr_VAddr, 0);
        check("rst_rsp_raddr", bus.Rsp_RAddr, 0);
        check("rst_misc", {bus.RW_En, bus.CP0_RdReq, bus.CP0_WrReq, bus.CP0_MMU_Func,
                           bus.IF_Ack, bus.DM_Ack, bus.Rsp_Fault, bus.Rsp_Err,
                           bus.Rsp_Timeout, bus.CP0_Ack}, 0);
        Reset = 1'b1;
        tick();

        // IF translation, MMU acks one cycle after Pr_Req
        bus.IF_Req   = 1'b1;
        bus.IF_VAddr = 32'h0040_1234;
        #1;
        check("t1_c0_pr_req", bus.Pr_Req, 0);
        tick();
        check("t1_c1_pr_req", bus.Pr_Req, 1);
        check("t1_c1_vaddr", bus.Pr_VAddr, 32'h0040_1234);
        check("t1_c1_rw", bus.RW_En, 0);
        tick();
        check("t1_c2_pr_req", bus.Pr_Req, 1);
        check("t1_c2_if_ack", bus.IF_Ack, 0);
        bus.MMU_Pr_Ack   = 1'b1;
        bus.MMU_Pr_RAddr = 32'h0001_2234;
        bus.TLB_Fault    = 3'd0;
        bus.TLB_Error    = 1'b0;
        tick();
        bus.MMU_Pr_Ack = 1'b0;
        bus.IF_Req     = 1'b0;
        #1;
        check("t1_c3_pr_req", bus.Pr_Req, 0);
        check("t1_c3_if_ack", bus.IF_Ack, 1);
        check("t1_c3_dm_ack", bus.DM_Ack, 0);
        check("t1_c3_raddr", bus.Rsp_RAddr, 32'h0001_2234);
        check("t1_c3_err", {bus.Rsp_Err, bus.Rsp_Timeout}, 0);
        tick();
        check("t1_c4_if_ack", bus.IF_Ack, 0);
        check("t1_c4_state", fsm_state, 0);
        tick();
        check("t1_c5_pr_req", bus.Pr_Req, 0);
        check("t1_c5_raddr_hold", bus.Rsp_RAddr, 32'h0001_2234);

        // IF and DM held together for four transactions
        do_reset();
`ifdef MMU_ARB_RR_EN
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`endif
        bus.IF_Req   = 1'b1;
        bus.IF_VAddr = 32'h0040_2000;
        bus.DM_Req   = 1'b1;
        bus.DM_VAddr = 32'h1000_0100;
        bus.DM_Wr    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pr_txn(32'h0002_0000 + 32'(i), 3'(i + 1), i[0], lat, va, rw, gi, gd);
            exp_dm = exp_q.pop_front();
            check("t2_lat", lat, (i == 0) ? 1 : 2);
            check("t2_grant_dm", gd, exp_dm);
            check("t2_grant_if", gi, !exp_dm);
            check("t2_vaddr", va, exp_dm ? 32'h1000_0100 : 32'h0040_2000);
            check("t2_rw", rw, exp_dm);
            check("t2_raddr", bus.Rsp_RAddr, 32'h0002_0000 + 32'(i));
            check("t2_fault", bus.Rsp_Fault, i + 1);
            check("t2_err", bus.Rsp_Err, i[0]);
        end
        bus.IF_Req = 1'b0;
        bus.DM_Req = 1'b0;
        bus.DM_Wr  = 1'b0;
        tick();
        tick();
        check("t2_idle_pr_req", bus.Pr_Req, 0);

        // CP0 TLBP and DM requested in the same cycle
        bus.CP0_Req  = 1'b1;
        bus.CP0_Wr   = 1'b0;
        bus.CP0_Func = TLBP;
        bus.DM_Req   = 1'b1;
        bus.DM_VAddr = 32'h8000_1000;
        bus.DM_Wr    = 1'b0;
        tick();
        check("t3_c1_rdreq", bus.CP0_RdReq, 1);
        check("t3_c1_pr_req", bus.Pr_Req, 0);
        check("t3_c1_func", bus.CP0_MMU_Func, TLBP);
        check("t3_c1_cp0_ack", bus.CP0_Ack, 0);
        check("t3_c1_state", fsm_state, 3);
        tick();
        bus.MMU_CP0_AckP = 1'b1;
        #1;
        check("t3_c2_cp0_ack", bus.CP0_Ack, 1);
        check("t3_c2_rdreq", bus.CP0_RdReq, 1);
        check("t3_c2_pr_req", bus.Pr_Req, 0);
        tick();
        bus.MMU_CP0_AckP = 1'b0;
        bus.CP0_Req      = 1'b0;
        #1;
        check("t3_c3_rdreq", bus.CP0_RdReq, 0);
        check("t3_c3_cp0_ack", bus.CP0_Ack, 0);
        check("t3_c3_pr_req", bus.Pr_Req, 0);
        pr_txn(32'h0003_3000, 3'd2, 1'b1, lat, va, rw, gi, gd);
        check("t3_dm_lat", lat, 1);
        check("t3_dm_ack", {gi, gd}, 2'b01);
        check("t3_dm_vaddr", va, 32'h8000_1000);
        check("t3_dm_rw", rw, 0);
        check("t3_raddr", bus.Rsp_RAddr, 32'h0003_3000);
        check("t3_fault", bus.Rsp_Fault, 2);
        check("t3_err_to", {bus.Rsp_Err, bus.Rsp_Timeout}, 2'b10);
        bus.DM_Req = 1'b0;
        tick();
        tick();

        // DM store, MMU never acks
        bus.DM_Req   = 1'b1;
        bus.DM_Wr    = 1'b1;
        bus.DM_VAddr = 32'h1000_0040;
        tick();
        check("t4_c1_pr_req", bus.Pr_Req, 1);
        check("t4_c1_rw", bus.RW_En, 1);
        n = 0;
        pr_dropped = 1'b0;
        while (!bus.DM_Ack && n < 40) begin
            if (!bus.Pr_Req) pr_dropped = 1'b1;
            tick();
            n++;
        end
        check("t4_to_cycles", n, 15);
        check("t4_pr_held", pr_dropped, 0);
        check("t4_pr_req_done", bus.Pr_Req, 0);
        check("t4_raddr", bus.Rsp_RAddr, 0);
        check("t4_fault", bus.Rsp_Fault, 0);
        check("t4_err_to", {bus.Rsp_Err, bus.Rsp_Timeout}, 2'b11);
        bus.DM_Req = 1'b0;
        bus.DM_Wr  = 1'b0;
        tick();
        tick();

        // CP0 TLBR, MMU never acks
        bus.CP0_Req  = 1'b1;
        bus.CP0_Wr   = 1'b0;
        bus.CP0_Func = TLBR;
        tick();
        n = 0;
        while (!bus.CP0_Ack && n < 40) begin
            tick();
            n++;
        end
        check("t4b_cp0_to_cycles", n, 14);
        check("t4b_rdreq", bus.CP0_RdReq, 1);
        bus.CP0_Req = 1'b0;
        tick();
        check("t4b_after_rdreq", bus.CP0_RdReq, 0);
        check("t4b_rsp_hold", bus.Rsp_Timeout, 1);

        // TLBWI
        bus.CP0_Req = 1'b1;
        bus.CP0_Wr  = 1'b1;
        tick();
        check("t5_c1_wrreq", bus.CP0_WrReq, 1);
        check("t5_c1_cp0_ack", bus.CP0_Ack, 1);
        check("t5_c1_others", {bus.CP0_RdReq, bus.Pr_Req}, 0);
        bus.CP0_Req = 1'b0;
        bus.CP0_Wr  = 1'b0;
        tick();
        check("t5_c2_wrreq", bus.CP0_WrReq, 0);
        check("t5_c2_cp0_ack", bus.CP0_Ack, 0);
        check("t5_c2_state", fsm_state, 0);

        // reset during PR_ISSUE with IF_Req held
        bus.IF_Req   = 1'b1;
        bus.IF_VAddr = 32'h0040_5678;
        tick();
        check("t6_c1_pr_req", bus.Pr_Req, 1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check("t6_rst_pr_req", bus.Pr_Req, 0);
        check("t6_rst_acks", {bus.IF_Ack, bus.DM_Ack, bus.CP0_Ack}, 0);
        check("t6_rst_vaddr", bus.Pr_VAddr, 0);
        check("t6_rst_rsp", {bus.Rsp_Fault, bus.Rsp_Err, bus.Rsp_Timeout}, 0);
        check("t6_rst_state", fsm_state, 0);
        tick();
        check("t6_rearb_pr_req", bus.Pr_Req, 1);
        check("t6_rearb_vaddr", bus.Pr_VAddr, 32'h0040_5678);
        pr_txn(32'h0004_5678, 3'd0, 1'b0, lat, va, rw, gi, gd);
        check("t6_if_ack", {gi, gd}, 2'b10);
        bus.IF_Req = 1'b0;
        tick();

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
